// File: rtl/float64_pkg.sv
// Purpose: shared binary64 constants, FSM encoding and NaN helpers for the float64 callees.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package float64_pkg;

    localparam logic [10:0] EXP_INF         = 11'h7FF;
    localparam int          QUIET_BIT       = 51;
    localparam logic [63:0] IMPLICIT_BIT_62 = 64'h4000_0000_0000_0000;
    localparam logic [63:0] IMPLICIT_BIT_61 = 64'h2000_0000_0000_0000;
    localparam logic [9:0]  ROUND_INC       = 10'h200;
    localparam logic [10:0] EXP_MAX_FINITE  = 11'h7FD;

    // One-hot call sequencer encoding
    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_ALIGN = 5'b00010,
        S_ADD   = 5'b00100,
        S_ROUND = 5'b01000,
        S_DONE  = 5'b10000
    } state_e;

    function automatic logic is_nan(input logic [63:0] x);
        return (x[62:52] == EXP_INF) && (x[51:0] != 52'd0);
    endfunction

    function automatic logic is_snan(input logic [63:0] x);
        return (x[62:51] == {EXP_INF, 1'b0}) && (x[50:0] != 51'd0);
    endfunction

    function automatic logic [63:0] quiet(input logic [63:0] x);
        return x | (64'd1 << QUIET_BIT);
    endfunction

    // A NaN keeps its own sign; b wins only when a is signalling and b is also a NaN
    function automatic logic [63:0] propagate_nan(input logic [63:0] a, input logic [63:0] b);
        logic [63:0] r;
        if (is_nan(a)) begin
            r = (is_snan(a) && is_nan(b)) ? quiet(b) : quiet(a);
        end else begin
            r = quiet(b);
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_right_jam64.sv
// Purpose: 64-bit logical right shift that ORs every shifted-out bit into bit 0 (sticky).
// Latency: combinational.
// Backpressure: none.
module shift_right_jam64 (
    input  logic [63:0] dat_i,
    input  logic [11:0] cnt_i,
    output logic [63:0] dat_o
);

    logic [63:0] lost_mask;

    // Counts of 64 or more collapse the whole value into the sticky bit
    always_comb begin
        lost_mask = ~({64{1'b1}} << cnt_i[5:0]);
        if (cnt_i >= 12'd64) begin
            dat_o = {63'd0, |dat_i};
        end else begin
            dat_o = (dat_i >> cnt_i[5:0]) | {63'd0, |(dat_i & lost_mask)};
        end
    end

endmodule

// File: rtl/add_float64_sigs.sv
// Purpose: adds binary64 magnitudes of a and b, applies zSign, round-to-nearest-even.
// Latency: fixed; start accepted at edge k gives ap_done/ap_ready after edge k+3.
// Backpressure: ap_ctrl_hs responder; new call only accepted in S_IDLE (1 call per 5 cycles).
module add_float64_sigs
    import float64_pkg::*;
(
    input  logic        ap_clk,
    input  logic        ap_rst_n,
    input  logic        ap_start,
    output logic        ap_done,
    output logic        ap_idle,
    output logic        ap_ready,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        zSign,
    output logic [63:0] ap_return
);

    state_e      state_q, state_d;
    logic [63:0] a_q, a_d, b_q, b_d;
    logic        zsign_q, zsign_d;
    logic [63:0] asig_q, asig_d, bsig_q, bsig_d, zsig_q, zsig_d;
    logic [11:0] zexp_q, zexp_d;
    logic        byp_q, byp_d;      // result already final, rounding skipped
    logic        eq_q, eq_d;        // equal exponents, S_ADD leaves zSig alone
    logic [63:0] res_q, res_d;      // final result for bypassed cases
    logic [63:0] ret_q, ret_d;
    logic        done_q, done_d;
    logic        idle_q, idle_d;

    logic [10:0] a_exp, b_exp;
    logic [63:0] a_sig, b_sig;
    logic [11:0] exp_diff, exp_neg;
    logic        diff_pos, diff_neg;
    logic [63:0] jam_in, jam_out;
    logic [11:0] jam_cnt;
    logic [63:0] add_sum;
    logic [63:0] rnd_sum, rnd_mant;
    logic [10:0] rnd_exp;
    logic        rnd_ovf;

    // Alignment operands: pick the smaller-exponent significand and its shift count
    always_comb begin
        a_exp    = a_q[62:52];
        b_exp    = b_q[62:52];
        a_sig    = {3'd0, a_q[51:0], 9'd0};
        b_sig    = {3'd0, b_q[51:0], 9'd0};
        exp_diff = {1'b0, a_exp} - {1'b0, b_exp};
        exp_neg  = 12'd0 - exp_diff;
        diff_neg = exp_diff[11];
        diff_pos = !exp_diff[11] && (exp_diff != 12'd0);
        jam_in   = 64'd0;
        jam_cnt  = 12'd0;
        if (diff_pos) begin
            jam_in  = (b_exp == 11'd0) ? b_sig : (b_sig | IMPLICIT_BIT_61);
            jam_cnt = (b_exp == 11'd0) ? (exp_diff - 12'd1) : exp_diff;
        end else if (diff_neg) begin
            jam_in  = (a_exp == 11'd0) ? a_sig : (a_sig | IMPLICIT_BIT_61);
            jam_cnt = (a_exp == 11'd0) ? (exp_neg - 12'd1) : exp_neg;
        end
    end

    shift_right_jam64 u_jam (
        .dat_i (jam_in),
        .cnt_i (jam_cnt),
        .dat_o (jam_out)
    );

    // Significand sum and rounding arithmetic on the registered working values
    always_comb begin
        add_sum  = (asig_q | IMPLICIT_BIT_61) + bsig_q;
        rnd_sum  = zsig_q + {54'd0, ROUND_INC};
        // bit 63 of the rounded sum set means the exponent would step past the finite range
        rnd_ovf  = (zexp_q > {1'b0, EXP_MAX_FINITE}) ||
                   ((zexp_q == {1'b0, EXP_MAX_FINITE}) && rnd_sum[63]);
        rnd_mant = rnd_sum >> 10;
        if (zsig_q[9:0] == ROUND_INC) begin
            rnd_mant[0] = 1'b0;
        end
        rnd_exp  = (rnd_mant == 64'd0) ? 11'd0 : zexp_q[10:0];
    end

    // Call sequencer and datapath next-state
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        zsign_d = zsign_q;
        asig_d  = asig_q;
        bsig_d  = bsig_q;
        zsig_d  = zsig_q;
        zexp_d  = zexp_q;
        byp_d   = byp_q;
        eq_d    = eq_q;
        res_d   = res_q;
        ret_d   = ret_q;
        done_d  = 1'b0;
        idle_d  = idle_q;
        case (state_q)
            S_IDLE: begin
                if (ap_start) begin
                    a_d     = a;
                    b_d     = b;
                    zsign_d = zSign;
                    idle_d  = 1'b0;
                    state_d = S_ALIGN;
                end
            end
            S_ALIGN: begin
                byp_d = 1'b0;
                eq_d  = 1'b0;
                res_d = 64'd0;
                if (diff_pos) begin
                    if (a_exp == EXP_INF) begin
                        byp_d = 1'b1;
                        res_d = (a_sig != 64'd0) ? propagate_nan(a_q, b_q) : {zsign_q, a_q[62:0]};
                    end
                    asig_d = a_sig;
                    bsig_d = jam_out;
                    zexp_d = {1'b0, a_exp};
                end else if (diff_neg) begin
                    if (b_exp == EXP_INF) begin
                        byp_d = 1'b1;
                        res_d = (b_sig != 64'd0) ? propagate_nan(a_q, b_q) : {zsign_q, b_q[62:0]};
                    end
                    asig_d = jam_out;
                    bsig_d = b_sig;
                    zexp_d = {1'b0, b_exp};
                end else begin
                    eq_d   = 1'b1;
                    asig_d = a_sig;
                    bsig_d = b_sig;
                    zexp_d = {1'b0, a_exp};
                    if (a_exp == EXP_INF) begin
                        byp_d = 1'b1;
                        res_d = ((a_sig | b_sig) != 64'd0) ? propagate_nan(a_q, b_q)
                                                           : {zsign_q, EXP_INF, 52'd0};
                    end else if (a_exp == 11'd0) begin
                        // Two subnormals: the fraction sum carries into the exponent field naturally
                        byp_d = 1'b1;
                        res_d = {zsign_q, 63'd0} + ((a_sig + b_sig) >> 9);
                    end else begin
                        zsig_d = IMPLICIT_BIT_62 + a_sig + b_sig;
                    end
                end
                state_d = S_ADD;
            end
            S_ADD: begin
                if (!byp_q && !eq_q) begin
                    if (add_sum[62]) begin
                        zsig_d = add_sum;
                    end else begin
                        zsig_d = add_sum << 1;
                        zexp_d = zexp_q - 12'd1;
                    end
                end
                state_d = S_ROUND;
            end
            S_ROUND: begin
                if (byp_q) begin
                    ret_d = res_q;
                end else if (rnd_ovf) begin
                    ret_d = {zsign_q, EXP_INF, 52'd0};
                end else begin
                    ret_d = {zsign_q, 63'd0} + {1'b0, rnd_exp, 52'd0} + rnd_mant;
                end
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                idle_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                idle_d  = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any call in flight
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= S_IDLE;
            a_q     <= 64'd0;
            b_q     <= 64'd0;
            zsign_q <= 1'b0;
            asig_q  <= 64'd0;
            bsig_q  <= 64'd0;
            zsig_q  <= 64'd0;
            zexp_q  <= 12'd0;
            byp_q   <= 1'b0;
            eq_q    <= 1'b0;
            res_q   <= 64'd0;
            ret_q   <= 64'd0;
            done_q  <= 1'b0;
            idle_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            zsign_q <= zsign_d;
            asig_q  <= asig_d;
            bsig_q  <= bsig_d;
            zsig_q  <= zsig_d;
            zexp_q  <= zexp_d;
            byp_q   <= byp_d;
            eq_q    <= eq_d;
            res_q   <= res_d;
            ret_q   <= ret_d;
            done_q  <= done_d;
            idle_q  <= idle_d;
        end
    end

    assign ap_done   = done_q;
    assign ap_ready  = done_q;
    assign ap_idle   = idle_q;
    assign ap_return = ret_q;

endmodule

// File: tb/tb_add_float64_sigs.sv
// Purpose: self-checking bench for add_float64_sigs against an IEEE real-arithmetic model.
// Latency: expects ap_done four edges after acceptance.
// Backpressure: caller holds ap_start until ap_ready.
module tb_add_float64_sigs;

    logic        ap_clk;
    logic        ap_rst_n;
    logic        ap_start;
    logic        ap_done;
    logic        ap_idle;
    logic        ap_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic        zSign;
    logic [63:0] ap_return;

    int checks   = 0;
    int failures = 0;

    add_float64_sigs dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .ap_start  (ap_start),
        .ap_done   (ap_done),
        .ap_idle   (ap_idle),
        .ap_ready  (ap_ready),
        .a         (a),
        .b         (b),
        .zSign     (zSign),
        .ap_return (ap_return)
    );

    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    // Reference: NaN rule stated directly, otherwise host IEEE double addition of magnitudes
    function automatic logic [63:0] ref_add(input logic [63:0] x, input logic [63:0] y, input logic zs);
        logic        x_nan, y_nan, x_snan;
        logic [63:0] qbit;
        real         rx, ry, rs;
        logic [63:0] bits;
        qbit   = 64'd1 << 51;
        x_nan  = (x[62:52] == 11'h7FF) && (x[51:0] != 52'd0);
        y_nan  = (y[62:52] == 11'h7FF) && (y[51:0] != 52'd0);
        x_snan = x_nan && !x[51];
        if (x_nan) return (x_snan && y_nan) ? (y | qbit) : (x | qbit);
        if (y_nan) return y | qbit;
        if (x[62:52] == 11'h7FF || y[62:52] == 11'h7FF) return {zs, 11'h7FF, 52'd0};
        rx   = $bitstoreal({1'b0, x[62:0]});
        ry   = $bitstoreal({1'b0, y[62:0]});
        rs   = rx + ry;
        bits = $realtobits(rs);
        return {zs, bits[62:0]};
    endfunction

    function automatic logic [63:0] rand64();
        logic [31:0] hi, lo;
        hi = $urandom();
        lo = $urandom();
        return {hi, lo};
    endfunction

    // Drives one call; lat is the edge count from acceptance to ap_ready, -1 on timeout
    task automatic run_call(input logic [63:0] av, input logic [63:0] bv, input logic zs,
                            output logic [63:0] res, output int lat);
        lat = -1;
        res = 64'd0;
        @(negedge ap_clk);
        a = av; b = bv; zSign = zs; ap_start = 1'b1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(posedge ap_clk);
            #1;
            if (cyc == 1) begin
                a = rand64(); b = rand64(); zSign = ~zs;
            end
            @(negedge ap_clk);
            if (ap_ready) begin
                lat = cyc;
                res = ap_return;
                break;
            end
        end
        ap_start = 1'b0;
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0; ap_start = 1'b0; a = 64'd0; b = 64'd0; zSign = 1'b0;
        repeat (3) @(posedge ap_clk);
        @(negedge ap_clk);
        checks++; if (ap_idle !== 1'b1) begin failures++; $display("FAIL reset_idle got=%b want=1", ap_idle); end
        checks++; if (ap_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", ap_done); end
        checks++; if (ap_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b want=0", ap_ready); end
        checks++; if (ap_return !== 64'd0) begin failures++; $display("FAIL reset_return got=%h want=0", ap_return); end
        ap_rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [63:0] va [6];
        logic [63:0] vb [6];
        logic        vz [6];
        logic [63:0] ve [6];
        logic [63:0] r;
        int          lat;
        va[0] = 64'h3FF0000000000000; vb[0] = 64'h3FF0000000000000; vz[0] = 1'b0; ve[0] = 64'h4000000000000000;
        va[1] = 64'h3FF0000000000000; vb[1] = 64'h3CA0000000000000; vz[1] = 1'b0; ve[1] = 64'h3FF0000000000000;
        va[2] = 64'h3CA0000000000000; vb[2] = 64'h3FF0000000000000; vz[2] = 1'b0; ve[2] = 64'h3FF0000000000000;
        va[3] = 64'h7FEFFFFFFFFFFFFF; vb[3] = 64'h7FEFFFFFFFFFFFFF; vz[3] = 1'b0; ve[3] = 64'h7FF0000000000000;
        va[4] = 64'h0000000000000001; vb[4] = 64'h0000000000000001; vz[4] = 1'b1; ve[4] = 64'h8000000000000002;
        va[5] = 64'h7FF0000000000001; vb[5] = 64'h3FF0000000000000; vz[5] = 1'b0; ve[5] = 64'h7FF8000000000001;
        for (int i = 0; i < 6; i++) begin
            run_call(va[i], vb[i], vz[i], r, lat);
            checks++; if (lat !== 4) begin failures++; $display("FAIL directed_latency[%0d] got=%0d want=4", i, lat); end
            checks++; if (r !== ve[i]) begin failures++; $display("FAIL directed_result[%0d] got=%h want=%h", i, r, ve[i]); end
        end
    endtask

    task automatic test_handshake();
        int          pulses, lat, idle_bad, sync_bad, stable_bad;
        logic [63:0] snap;
        pulses = 0; lat = -1; idle_bad = 0; sync_bad = 0; stable_bad = 0; snap = 64'd0;
        @(negedge ap_clk);
        a = 64'h3FF0000000000000; b = 64'h3FF0000000000000; zSign = 1'b0; ap_start = 1'b1;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(posedge ap_clk);
            @(negedge ap_clk);
            if (ap_done !== ap_ready) sync_bad++;
            if (lat > 0 && ap_return !== snap) stable_bad++;
            if (ap_done === 1'b1) begin
                pulses++;
                if (lat < 0) lat = cyc;
                snap = ap_return;
                ap_start = 1'b0;
            end
            if (cyc <= 4 && ap_idle !== 1'b0) idle_bad++;
            if (cyc >= 5 && ap_idle !== 1'b1) idle_bad++;
        end
        ap_start = 1'b0;
        checks++; if (pulses !== 1) begin failures++; $display("FAIL hs_pulses got=%0d want=1", pulses); end
        checks++; if (lat !== 4) begin failures++; $display("FAIL hs_latency got=%0d want=4", lat); end
        checks++; if (idle_bad !== 0) begin failures++; $display("FAIL hs_idle bad_cycles=%0d want=0", idle_bad); end
        checks++; if (sync_bad !== 0) begin failures++; $display("FAIL hs_done_ready bad_cycles=%0d want=0", sync_bad); end
        checks++; if (stable_bad !== 0) begin failures++; $display("FAIL hs_return_stable bad_cycles=%0d want=0", stable_bad); end
        checks++; if (snap !== 64'h4000000000000000) begin failures++; $display("FAIL hs_result got=%h want=4000000000000000", snap); end
    endtask

    task automatic test_random();
        logic [63:0] av, bv, r, exp_r;
        logic        zs;
        int          lat, mode, e;
        for (int i = 0; i < 160; i++) begin
            av = rand64(); bv = rand64(); zs = 1'($urandom_range(0, 1));
            mode = int'($urandom_range(0, 6));
            case (mode)
                1: begin
                    e = int'(av[62:52]) + int'($urandom_range(0, 6)) - 3;
                    if (e < 0) e = 0;
                    if (e > 2046) e = 2046;
                    if (av[62:52] == 11'h7FF) av[62:52] = 11'h400;
                    bv[62:52] = e[10:0];
                end
                2: begin av[62:52] = 11'd0; bv[62:52] = 11'($urandom_range(0, 1)); end
                3: begin av[62:52] = 11'h7FF; if ($urandom_range(0, 1) == 1) av[51:0] = 52'd0; end
                4: begin bv[62:52] = 11'h7FF; if ($urandom_range(0, 1) == 1) av[62:52] = 11'h7FF; end
                5: begin
                    av[62:52] = 11'h7FE - 11'($urandom_range(0, 2));
                    bv[62:52] = 11'h7FE - 11'($urandom_range(0, 2));
                end
                6: begin
                    if (av[62:52] == 11'h7FF) av[62:52] = 11'h500;
                    e = int'(av[62:52]) - int'($urandom_range(50, 70));
                    if (e < 0) e = 0;
                    bv[62:52] = e[10:0];
                end
                default: ;
            endcase
            exp_r = ref_add(av, bv, zs);
            run_call(av, bv, zs, r, lat);
            checks++; if (lat !== 4) begin failures++; $display("FAIL rand_latency[%0d] got=%0d want=4", i, lat); end
            checks++; if (r !== exp_r) begin
                failures++;
                $display("FAIL rand_result[%0d] a=%h b=%h zs=%b got=%h want=%h", i, av, bv, zs, r, exp_r);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] va [4];
        logic [63:0] vb [4];
        logic        vz [4];
        int          idx, last;
        for (int i = 0; i < 4; i++) begin
            va[i] = rand64(); vb[i] = rand64(); vz[i] = 1'($urandom_range(0, 1));
        end
        idx = 0; last = -1;
        @(negedge ap_clk);
        a = va[0]; b = vb[0]; zSign = vz[0]; ap_start = 1'b1;
        for (int cyc = 1; cyc <= 60 && idx < 4; cyc++) begin
            @(posedge ap_clk);
            @(negedge ap_clk);
            if (ap_done === 1'b1) begin
                checks++; if (ap_return !== ref_add(va[idx], vb[idx], vz[idx])) begin
                    failures++;
                    $display("FAIL b2b_result[%0d] got=%h want=%h", idx, ap_return, ref_add(va[idx], vb[idx], vz[idx]));
                end
                if (idx > 0) begin
                    checks++; if (cyc - last !== 5) begin failures++; $display("FAIL b2b_period[%0d] got=%0d want=5", idx, cyc - last); end
                end
                last = cyc;
                idx++;
                if (idx < 4) begin
                    a = va[idx]; b = vb[idx]; zSign = vz[idx];
                end else begin
                    ap_start = 1'b0;
                end
            end
        end
        ap_start = 1'b0;
        checks++; if (idx !== 4) begin failures++; $display("FAIL b2b_calls_done got=%0d want=4", idx); end
    endtask

    task automatic test_reset_mid();
        int done_seen;
        done_seen = 0;
        @(negedge ap_clk);
        a = 64'h4000000000000000; b = 64'h3FF0000000000000; zSign = 1'b0; ap_start = 1'b1;
        @(posedge ap_clk);
        @(posedge ap_clk);
        @(negedge ap_clk);
        ap_start = 1'b0;
        ap_rst_n = 1'b0;
        #1;
        checks++; if (ap_idle !== 1'b1) begin failures++; $display("FAIL midrst_idle got=%b want=1", ap_idle); end
        checks++; if (ap_return !== 64'd0) begin failures++; $display("FAIL midrst_return got=%h want=0", ap_return); end
        checks++; if (ap_done !== 1'b0) begin failures++; $display("FAIL midrst_done got=%b want=0", ap_done); end
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        repeat (8) begin
            @(posedge ap_clk);
            @(negedge ap_clk);
            if (ap_done === 1'b1) done_seen++;
        end
        checks++; if (done_seen !== 0) begin failures++; $display("FAIL midrst_no_done got=%0d want=0", done_seen); end
        checks++; if (ap_idle !== 1'b1) begin failures++; $display("FAIL midrst_idle_after got=%b want=1", ap_idle); end
    endtask

    task automatic test_recover();
        logic [63:0] r;
        int          lat;
        run_call(64'h4000000000000000, 64'h3FF0000000000000, 1'b1, r, lat);
        checks++; if (lat !== 4) begin failures++; $display("FAIL recover_latency got=%0d want=4", lat); end
        checks++; if (r !== 64'hC008000000000000) begin failures++; $display("FAIL recover_result got=%h want=c008000000000000", r); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_handshake();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_recover();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
